instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage directly upstream of the decoder: owns the program counter, issues in-order word reads to instruction memory and buffers returned instructions in a small queue. It presents `{instr, pc}` pairs to decode over a valid/ready handshake. It discards wrong-path fetches when a branch/jump redirect arrives from later stages.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000, PC loaded on reset.
- `DEPTH`, 4, instruction queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_req_addr`  out  32  word address (bits [1:0] always 0).
- `imem_rsp_valid`  in  1  read data returned; in request order, latency ≥1 cycle.
- `imem_rsp_data`  in  32  instruction word.
- `redirect`  in  1  taken branch/jump/exception target from execute.
- `redirect_pc`  in  32  new fetch target; bits [1:0] ignored (treated as 0).
- `dec_valid`  out  1  queue head valid.
- `dec_ready`  in  1  decoder consumes head this cycle.
- `dec_instr`  out  32  head instruction; 0 when `dec_valid`=0.
- `dec_pc`  out  32  head instruction's PC; 0 when `dec_valid`=0.

## Operation
- State: `pc` (next fetch address), queue (count 0..DEPTH), `outstanding` (accepted, unreturned requests), `drop` (stale responses still to discard). Counters are `$clog2(DEPTH+1)` bits wide.
- Issue rule: `imem_req_valid` = !reset && !redirect && (count + outstanding < DEPTH). Credit is reserved at issue, so a response always has a free slot.
  - `imem_req_addr` = `pc`.
  - On accept (valid && ready): `pc` <= `pc`+4, wrapping 32'hFFFF_FFFC→0; `outstanding`+1.
- Response: `outstanding`-1.
  - If `drop`>0: discard the data and decrement `drop`.
  - Otherwise push `{imem_rsp_data, pc_of_request}` into the queue. The request PC travels in a DEPTH-entry in-order tag FIFO.
- Pop: on `dec_valid && dec_ready`, count-1.
  - Push and pop in the same cycle are legal at any count, including full and empty.
  - A push into an empty queue is not bypassed.
- Redirect (highest priority, one-cycle pulse or held):
  - Queue flushed (count←0); any pop that cycle is ignored.
  - `pc` ← {redirect_pc[31:2],2'b00}; no request issued that cycle.
  - `drop` ← `outstanding` minus (1 if `imem_rsp_valid` this cycle), i.e. every in-flight request becomes stale. A response in the redirect cycle is discarded.
  - Redirect while `drop`>0 recomputes `drop` by the same rule.
- No FSM beyond these counters; "draining" is simply `drop`>0. Fetching of the new path may overlap draining.

## Timing
- Reset (sync): `pc`=RESET_PC; count=outstanding=drop=0. Outputs during and after the reset cycle: `imem_req_valid`=0 (during reset only), `dec_valid`=0, `dec_instr`=0, `dec_pc`=0.
- First request: `imem_req_valid`=1 in the first cycle after reset deasserts, addr=RESET_PC.
- Latency: a request accepted in cycle N with response in N+L gives `dec_valid` in cycle N+L+1.
- Throughput: one instruction per cycle sustained when L+1 ≤ DEPTH and decode never stalls.
- Redirect in cycle R: first new-path request in R+1, addr=`redirect_pc`. `dec_valid`=0 in R+1 at the earliest; the first new-path instruction appears at R+1+L+1.
- Decoder stall (`dec_ready`=0): the queue fills and `imem_req_valid` drops once count+outstanding=DEPTH. No data lost; `dec_instr`/`dec_pc` stable while `dec_valid && !dec_ready`.

## Structure
- Add `fetch_entry_t` {logic [31:0] instr; logic [31:0] pc;} to the shared `signals` package, together with the constant `RESET_VECTOR` = 32'hBFC0_0000 used as the default for `RESET_PC`.
- One sub-module: `fetch_fifo`, a parametric synchronous FIFO (DEPTH, element type) with push/pop/flush, count, and same-cycle push+pop at full. It is instantiated twice: once for the instruction queue and once for request-PC tags.

## Test plan
- Reset, memory latency L=1, `dec_ready`=1 → requests 0xBFC00000, …04, …08 on consecutive cycles; `dec_pc` sequence identical, first `dec_valid` 2 cycles after first accept.
- `dec_ready`=0 for 10 cycles, L=1, DEPTH=4 → exactly 4 requests issued, count=4, then `imem_req_valid`=0. Release gives 4 pops in order with no gaps or loss.
- L=3 with 2 requests in flight, redirect to 0x8000_0100 → both responses discarded (drop 2→0); next `dec_pc`=0x8000_0100 and no stale instruction ever has `dec_valid`=1.
- Redirect in the same cycle as `imem_rsp_valid` and `dec_ready` → response dropped, queue empty next cycle, no request that cycle, next addr = target.
- `pc`=0xFFFF_FFFC → next request addr 0x0000_0000; redirect_pc=0x1234_5677 → request addr 0x1234_5674.
- Reset asserted with queue full and 2 requests outstanding → all outputs at reset values the next cycle. The late responses arriving after reset are ignored by the memory model contract (bench flushes memory too).

Source files
------------

// File: rtl/signals_pkg.sv
// Shared types and constants for the front end of the pipeline.
// fetch_entry_t is the {instr, pc} pair handed from fetch to decode.
package signals;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally from the array.
// Same-cycle push and pop are accepted at any occupancy, including full.
module fetch_fifo
  import signals::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T               mem_reg [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           do_push;
  logic           do_pop;

  // A pop frees the slot the same-cycle push needs when full.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues in-order word reads with credit reserved in the
// instruction queue, and discards in-flight responses after a redirect.
module instruction_fetch
  import signals::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   pc_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_reg;
  logic [CW-1:0] drop_next;
  logic [CW-1:0] q_count;
  logic [CW-1:0] tag_count;
  logic [CW:0]   in_use;
  logic          accept;
  logic          rsp_keep;
  fetch_entry_t  q_head;
  fetch_entry_t  q_push_data;
  logic [31:0]   tag_head;

  // Outstanding requests count against queue space so every response has a slot.
  assign in_use         = {1'b0, q_count} + {1'b0, outstanding_reg};
  assign imem_req_valid = !reset && !redirect && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_reg;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && !redirect && (drop_reg == '0) && (tag_count != '0);

  always_comb begin
    outstanding_next = outstanding_reg;
    if (accept)         outstanding_next = outstanding_next + CW'(1);
    if (imem_rsp_valid) outstanding_next = outstanding_next - CW'(1);
  end

  // No request issues in a redirect cycle, so outstanding_next is exactly the
  // set of requests that are now on the wrong path.
  always_comb begin
    drop_next = drop_reg;
    if (redirect)
      drop_next = outstanding_next;
    else if (imem_rsp_valid && (drop_reg != '0))
      drop_next = drop_reg - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      if (redirect)    pc_reg <= word_align(redirect_pc);
      else if (accept) pc_reg <= pc_reg + 32'd4;
    end
  end

  // Tags are flushed on redirect; stale responses are absorbed by drop_reg instead.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [31:0])
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (accept),
    .push_data (pc_reg),
    .pop       (rsp_keep),
    .head      (tag_head),
    .count     (tag_count)
  );

  assign q_push_data = '{instr: imem_rsp_data, pc: tag_head};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_instr_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (rsp_keep),
    .push_data (q_push_data),
    .pop       (dec_valid && dec_ready),
    .head      (q_head),
    .count     (q_count)
  );

  assign dec_valid = !reset && (q_count != '0);
  assign dec_instr = dec_valid ? q_head.instr : 32'd0;
  assign dec_pc    = dec_valid ? q_head.pc    : 32'd0;

endmodule
